// File: rtl/pieo_enq_tracker_drr.sv
// ============================================================================
// Module      : pieo_enq_tracker_drr
// Description : DRR PIEO enqueue-side tracker. It issues one round-robin enqueue
//               per flow FIFO that holds data but owns no PIEO entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pieo_enq_tracker_drr #(
    parameter int NUM_QUEUES = 3,
    parameter int ID_LOG     = $clog2(NUM_QUEUES),
    parameter int RANK_LOG   = 1,
    parameter int TIME_LOG   = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 en_in,
    input  logic [NUM_QUEUES-1:0]                fifo_tvalid,
    input  logic [NUM_QUEUES-1:0]                post_deq_end,
    input  logic                                 pieo_ready,
    output logic                                 pieo_enq_valid,
    output logic [ID_LOG+RANK_LOG+TIME_LOG-1:0]  pieo_enq_element,
    output logic                                 fifos_not_enq_flag,
    output logic [NUM_QUEUES-1:0]                enq_bitmap,
    output logic                                 err_sticky
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t                 state;
    logic [ID_LOG-1:0]      rr_ptr;
    logic [NUM_QUEUES-1:0]  cand;
    logic [ID_LOG-1:0]      sel;
    logic                   found;
    logic                   issue;
    int                     idx;
    logic [NUM_QUEUES-1:0]  set_mask;
    logic [NUM_QUEUES-1:0]  clr_mask;

    assign cand = fifo_tvalid & ~enq_bitmap;

    // Circular first-set search starting at the round-robin pointer.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_QUEUES; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_QUEUES) idx = idx - NUM_QUEUES;
            if (!found && cand[idx]) begin
                found = 1'b1;
                sel   = ID_LOG'(idx);
            end
        end
    end

    assign issue    = (state == IDLE) && en_in && pieo_ready && found;
    assign set_mask = issue ? (NUM_QUEUES'(1) << sel) : '0;
    // An end pulse for a FIFO without an entry is a protocol error, not a clear.
    assign clr_mask = post_deq_end & enq_bitmap;

    assign fifos_not_enq_flag = ((|cand) & en_in) | (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            enq_bitmap       <= '0;
            pieo_enq_valid   <= 1'b0;
            pieo_enq_element <= '0;
            err_sticky       <= 1'b0;
        end else begin
            enq_bitmap <= (enq_bitmap & ~clr_mask) | set_mask;
            err_sticky <= err_sticky | (|(post_deq_end & ~enq_bitmap));
            case (state)
                IDLE: begin
                    if (issue) begin
                        state            <= ISSUE;
                        pieo_enq_valid   <= 1'b1;
                        pieo_enq_element <= {{(RANK_LOG+TIME_LOG){1'b0}}, sel};
                        rr_ptr           <= (sel == ID_LOG'(NUM_QUEUES-1)) ? '0 : sel + 1'b1;
                    end
                end
                ISSUE: begin
                    state            <= GUARD;
                    pieo_enq_valid   <= 1'b0;
                    pieo_enq_element <= '0;
                end
                GUARD: begin
                    if (pieo_ready) state <= IDLE;
                end
                default: begin
                    state            <= IDLE;
                    pieo_enq_valid   <= 1'b0;
                    pieo_enq_element <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
